wb_elastic_stage: RTL and testbench

Parametrised elastic MEM→WB pipeline stage, successor to the fixed-width always-load MEM/WB register. It adds a valid/ready handshake, a one-entry skid buffer so upstream `in_ready` is fully registered, synchronous flush, bubble-safe control zeroing, and a built-in WB forwarding port. It sits between the MEM stage (data memory, ALU result) and the register-file write port.

---
 rtl/wb_pipe_pkg.sv | 23 ++
 rtl/wb_elastic_stage.sv | 92 +++++++++
 tb/tb_wb_elastic_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/wb_pipe_pkg.sv
// wb_pipe_pkg: shared MEM/WB pipeline types.
// Provides the stage state enum, the default field widths, and the
// reference entry layout at those default widths.
package wb_pipe_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int XCTRL_W_DEF = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                   regwrite;
        logic                   memtoreg;
        logic [XCTRL_W_DEF-1:0] xctrl;
        logic [ADDR_W_DEF-1:0]  addr;
        logic [DATA_W_DEF-1:0]  alu;
        logic [DATA_W_DEF-1:0]  mdout;
    } wb_entry_t;
endpackage

// File: rtl/wb_elastic_stage.sv
// wb_elastic_stage: elastic MEM->WB register with skid buffer and WB forwarding.
// Ports:
//   clk, reset (sync, active-high), flush (sync squash of held entries)
//   in_valid/in_ready + in_* fields      : MEM-side handshake (in_ready registered)
//   out_valid/out_ready + out_* fields   : WB-side handshake; control reads 0 in bubbles
//   fwd_en, fwd_addr, fwd_data           : forwarding view of the main entry
module wb_elastic_stage
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int XCTRL_W = XCTRL_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_regwrite,
    input  logic               in_memtoreg,
    input  logic [XCTRL_W-1:0] in_xctrl,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [DATA_W-1:0]  in_alu,
    input  logic [DATA_W-1:0]  in_mdout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_regwrite,
    output logic               out_memtoreg,
    output logic [XCTRL_W-1:0] out_xctrl,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [DATA_W-1:0]  out_alu,
    output logic [DATA_W-1:0]  out_mdout,
    output logic               fwd_en,
    output logic [ADDR_W-1:0]  fwd_addr,
    output logic [DATA_W-1:0]  fwd_data
);
    typedef struct packed {
        logic               regwrite;
        logic               memtoreg;
        logic [XCTRL_W-1:0] xctrl;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  mdout;
    } entry_t;

    wb_state_t state, state_nx;
    entry_t    main_q, skid_q, in_e;
    logic      in_fire, out_fire, load_main, load_skid;

    assign in_e      = '{in_regwrite, in_memtoreg, in_xctrl, in_addr, in_alu, in_mdout};
    assign in_fire   = in_valid & in_ready;
    assign out_valid = state != EMPTY;
    assign out_fire  = out_valid & out_ready;

    // Main takes the input when it is free or drained this cycle; it takes the
    // skid entry when draining out of SKID (in_ready is 0 there, so no conflict).
    assign load_main = (in_fire & (state == EMPTY | out_fire)) | (state == SKID & out_fire);
    assign load_skid = in_fire & state == FULL & ~out_fire;

    always_comb begin
        state_nx = flush           ? EMPTY :
                   state == EMPTY  ? (in_fire ? FULL : EMPTY) :
                   state == FULL   ? (load_skid ? SKID : (out_fire & ~in_fire) ? EMPTY : FULL) :
                   (out_fire ? FULL : SKID);
    end

    // Flush only retires entries; data registers hold so out_addr/alu/mdout
    // keep their last value through bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= state_nx != SKID;
            if (!flush && load_main) main_q <= state == SKID ? skid_q : in_e;
            if (!flush && load_skid) skid_q <= in_e;
        end
    end

    assign out_regwrite = out_valid & main_q.regwrite;
    assign out_memtoreg = out_valid & main_q.memtoreg;
    assign out_xctrl    = out_valid ? main_q.xctrl : '0;
    assign out_addr     = main_q.addr;
    assign out_alu      = main_q.alu;
    assign out_mdout    = main_q.mdout;
    assign fwd_en       = out_regwrite & (main_q.addr != '0);
    assign fwd_addr     = main_q.addr;
    assign fwd_data     = main_q.memtoreg ? main_q.mdout : main_q.alu;
endmodule

// File: tb/tb_wb_elastic_stage.sv
// tb_wb_elastic_stage: scoreboard bench for wb_elastic_stage against a queue model.
module tb_wb_elastic_stage;
    import wb_pipe_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset, flush, in_valid, in_ready, in_regwrite, in_memtoreg;
    logic [XCTRL_W_DEF-1:0] in_xctrl;
    logic [ADDR_W_DEF-1:0]  in_addr;
    logic [DATA_W_DEF-1:0]  in_alu, in_mdout;
    logic                   out_valid, out_ready, out_regwrite, out_memtoreg;
    logic [XCTRL_W_DEF-1:0] out_xctrl;
    logic [ADDR_W_DEF-1:0]  out_addr, fwd_addr;
    logic [DATA_W_DEF-1:0]  out_alu, out_mdout, fwd_data;
    logic                   fwd_en;

    wb_elastic_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_xctrl(in_xctrl),
        .in_addr(in_addr), .in_alu(in_alu), .in_mdout(in_mdout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regwrite(out_regwrite), .out_memtoreg(out_memtoreg), .out_xctrl(out_xctrl),
        .out_addr(out_addr), .out_alu(out_alu), .out_mdout(out_mdout),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Model: the stage is a FIFO of at most two accepted entries; the head is
    // what WB sees. Accept is allowed when fewer than two are held.
    wb_entry_t exp_q[$];
    wb_entry_t last_head = '0;
    wb_entry_t h;
    bit        v;
    bit        m_rdy = 1'b1;
    bit        mon_on = 1'b0;
    int        vectors = 0;
    int        miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic wb_entry_t mk(input bit rw, input bit mtr, input logic [XCTRL_W_DEF-1:0] xc,
                                     input logic [ADDR_W_DEF-1:0] a, input logic [DATA_W_DEF-1:0] alu,
                                     input logic [DATA_W_DEF-1:0] md);
        mk = '{rw, mtr, xc, a, alu, md};
    endfunction

    // Monitor: checks outputs mid-cycle against the model head, retires on out_fire.
    initial forever begin
        @(negedge clk);
        #3;
        if (mon_on) begin
            v     = exp_q.size() > 0;
            h     = v ? exp_q[0] : last_head;
            m_rdy = exp_q.size() < 2;
            chk("out_valid", 64'(out_valid), 64'(v));
            chk("in_ready", 64'(in_ready), 64'(m_rdy));
            chk("out_regwrite", 64'(out_regwrite), 64'(v & h.regwrite));
            chk("out_memtoreg", 64'(out_memtoreg), 64'(v & h.memtoreg));
            chk("out_xctrl", 64'(out_xctrl), v ? 64'(h.xctrl) : 64'd0);
            chk("out_addr", 64'(out_addr), 64'(h.addr));
            chk("out_alu", 64'(out_alu), 64'(h.alu));
            chk("out_mdout", 64'(out_mdout), 64'(h.mdout));
            chk("fwd_en", 64'(fwd_en), 64'(v & h.regwrite & (h.addr != 0)));
            chk("fwd_addr", 64'(fwd_addr), 64'(h.addr));
            if (v) begin
                chk("fwd_data", 64'(fwd_data), 64'(h.memtoreg ? h.mdout : h.alu));
                last_head = h;
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Driver: applies one cycle of stimulus and records accepted entries.
    task automatic step(input bit vld, input wb_entry_t e, input bit ordy, input bit fl, input bit rs);
        @(negedge clk);
        #1;
        in_valid    = vld;
        in_regwrite = e.regwrite;
        in_memtoreg = e.memtoreg;
        in_xctrl    = e.xctrl;
        in_addr     = e.addr;
        in_alu      = e.alu;
        in_mdout    = e.mdout;
        out_ready   = ordy;
        flush       = fl;
        reset       = rs;
        #3;
        if (rs) begin
            exp_q.delete();
            last_head = '0;
        end else if (fl) begin
            exp_q.delete();
        end else if (vld && m_rdy) begin
            exp_q.push_back(e);
        end
    endtask

    wb_entry_t z = '0;
    wb_entry_t re;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_regwrite = 1'b0; in_memtoreg = 1'b0; in_xctrl = '0;
        in_addr = '0; in_alu = '0; in_mdout = '0;
        step(0, z, 0, 0, 1);
        step(0, z, 0, 0, 1);
        mon_on = 1'b1;
        step(0, z, 1, 0, 0);
        for (int i = 1; i <= 4; i++)
            step(1, mk(1, 0, 1'b1, 5'(i), 32'h10 + 32'(i - 1), 32'hA0 + 32'(i)), 1, 0, 0);
        step(0, z, 1, 0, 0);
        step(1, mk(1, 0, 0, 5'd5, 32'h55, 32'h505), 0, 0, 0);
        step(1, mk(1, 1, 1, 5'd6, 32'h66, 32'h606), 0, 0, 0);
        step(1, mk(1, 0, 0, 5'd7, 32'h77, 32'h707), 0, 0, 0);
        step(0, z, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, z, 1, 0, 0);
        step(1, mk(1, 0, 0, 5'd9, 32'h99, 32'h909), 0, 0, 0);
        step(1, mk(1, 1, 1, 5'd10, 32'hAA, 32'hA0A), 0, 0, 0);
        step(0, z, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, z, 1, 0, 0);
        step(1, mk(1, 1, 0, 5'd8, 32'h1234, 32'hDEADBEEF), 1, 0, 0);
        step(1, mk(1, 1, 0, 5'd0, 32'h1234, 32'hDEADBEEF), 1, 0, 0);
        step(0, z, 1, 0, 0);
        step(1, mk(1, 0, 1, 5'd11, 32'hBB, 32'hB0B), 0, 0, 0);
        step(1, mk(1, 1, 1, 5'd12, 32'hCC, 32'hC0C), 0, 1, 1);
        step(0, z, 1, 0, 0);
        step(1, mk(1, 0, 1, 5'd13, 32'hDD, 32'hD0D), 1, 0, 0);
        step(1, mk(1, 1, 1, 5'd14, 32'hEE, 32'hE0E), 1, 1, 0);
        step(0, z, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            re = mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
            step($urandom_range(0, 9) < 7, re, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        step(0, z, 1, 0, 0);
        step(0, z, 1, 0, 0);
        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
